// File: rtl/pipeline_ctrl_pkg.sv
// Shared IR field layout, opcode/aluop constants and multdiv FSM states for pipeline_ctrl.
package pipeline_ctrl_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_JR    = 5'b00100;

    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    typedef struct packed {
        logic [4:0] opcode;  // [31:27]
        logic [4:0] rd;      // [26:22]
        logic [4:0] rs;      // [21:17]
        logic [4:0] rt;      // [16:12]
        logic [4:0] shamt;   // [11:7]
        logic [4:0] aluop;   // [6:2]
        logic [1:0] pad;     // [1:0]
    } ir_t;

    typedef enum logic [1:0] {
        IDLE,
        MD_BUSY,
        MD_DONE
    } md_state_e;

    function automatic logic is_muldiv(input ir_t ir);
        return (ir.opcode == OP_RTYPE) && ((ir.aluop == ALU_MUL) || (ir.aluop == ALU_DIV));
    endfunction

    // Instructions that use the rd field as a source operand.
    function automatic logic reads_rd(input ir_t ir);
        return (ir.opcode == OP_SW) || (ir.opcode == OP_BNE) ||
               (ir.opcode == OP_BLT) || (ir.opcode == OP_JR);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_md_sequencer.sv
// md_sequencer: IDLE/MD_BUSY/MD_DONE multdiv FSM with busy-cycle timeout and sticky error flag.
module md_sequencer
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MD_TIMEOUT = 40
) (
    input  logic clk,
    input  logic clr,
    input  logic md_req,
    input  logic md_ready,
    output logic md_start,
    output logic md_busy,
    output logic md_timeout
);

    localparam int unsigned CW = $clog2(MD_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MD_TIMEOUT - 1);

    md_state_e     state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          timeout_set;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= IDLE;
            cnt        <= '0;
            md_timeout <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            md_timeout <= md_timeout | timeout_set;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        timeout_set = 1'b0;
        md_start    = 1'b0;
        unique case (state)
            // md_ready is not looked at here: the unit cannot answer in its start cycle
            IDLE: begin
                if (md_req) begin
                    md_start  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = MD_BUSY;
                end
            end
            MD_BUSY: begin
                cnt_nxt = cnt + 1'b1;
                if (md_ready) begin
                    state_nxt = MD_DONE;
                end else if (cnt == CNT_LAST) begin
                    timeout_set = 1'b1;
                    state_nxt   = MD_DONE;
                end
            end
            MD_DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign md_busy = (state == MD_BUSY);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline latch control: load-use stalls, branch flushes and multdiv sequencing.
// Optional statistics counters are built when PIPE_STATS_EN is defined.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MD_TIMEOUT = 40,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [31:0]      fd_ir,
    input  logic [31:0]      dx_ir,
    input  logic             branch_taken,
    input  logic             md_ready,
    output logic             pc_en,
    output logic             fd_en,
    output logic             dx_en,
    output logic             xm_en,
    output logic             mw_en,
    output logic             fd_clr,
    output logic             dx_clr,
    output logic             xm_clr,
    output logic             md_start,
    output logic             md_busy,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    ir_t  fd, dx;
    logic load_use;
    logic seq_start, seq_busy;
    logic stall_ev, flush_ev;

    assign fd = ir_t'(fd_ir);
    assign dx = ir_t'(dx_ir);

    assign load_use = (dx.opcode == OP_LW) && (dx.rd != '0) &&
                      ((fd.rs == dx.rd) ||
                       ((fd.opcode == OP_RTYPE) && (fd.rt == dx.rd)) ||
                       (reads_rd(fd) && (fd.rd == dx.rd)));

    md_sequencer #(
        .MD_TIMEOUT (MD_TIMEOUT)
    ) u_md_seq (
        .clk        (clk),
        .clr        (clr),
        .md_req     (is_muldiv(dx)),
        .md_ready   (md_ready),
        .md_start   (seq_start),
        .md_busy    (seq_busy),
        .md_timeout (md_timeout)
    );

    assign md_start = seq_start & ~clr;
    assign md_busy  = seq_busy & ~clr;

    // Priority: reset > multdiv busy > branch flush > load-use bubble.
    always_comb begin
        pc_en    = 1'b1;
        fd_en    = 1'b1;
        dx_en    = 1'b1;
        xm_en    = 1'b1;
        mw_en    = 1'b1;
        fd_clr   = 1'b0;
        dx_clr   = 1'b0;
        xm_clr   = 1'b0;
        stall_ev = 1'b0;
        flush_ev = 1'b0;
        if (clr) begin
            pc_en  = 1'b0;
            fd_en  = 1'b0;
            dx_en  = 1'b0;
            xm_en  = 1'b0;
            mw_en  = 1'b0;
            fd_clr = 1'b1;
            dx_clr = 1'b1;
            xm_clr = 1'b1;
        end else if (seq_busy) begin
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            dx_en    = 1'b0;
            xm_clr   = 1'b1;
            stall_ev = 1'b1;
        end else if (branch_taken) begin
            fd_clr   = 1'b1;
            dx_clr   = 1'b1;
            flush_ev = 1'b1;
        end else if (load_use) begin
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            dx_clr   = 1'b1;
            stall_ev = 1'b1;
        end
    end

`ifdef PIPE_STATS_EN
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_ev && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_ev && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_stats;
    assign unused_stats = stall_ev ^ flush_ev;
    assign stall_cnt    = '0;
    assign flush_cnt    = '0;
`endif

    logic unused_ir;
    assign unused_ir = ^{fd.shamt, fd.aluop, fd.pad, dx.rs, dx.rt, dx.shamt, dx.pad};

endmodule
